// File: rtl/ascon_perm_sequencer_dom_if.sv
// Bundle of every load, result, randomness and datapath signal of the
// two-share Ascon permutation sequencer. The slave modport is the sequencer's
// view; the master modport is the view of the surrounding environment that
// also provides the masked round datapath.
interface ascon_perm_sequencer_dom_if;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] in_sh0;
  logic [319:0] in_sh1;
  logic [1:0]   rounds_sel;
  logic [319:0] rnd_in;
  logic         rnd_valid;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_sh0;
  logic [319:0] out_sh1;
  logic [319:0] dp_Xi_sh0;
  logic [319:0] dp_Xi_sh1;
  logic [319:0] dp_Xo_sh0;
  logic [319:0] dp_Xo_sh1;
  logic [1:0]   dp_rcmode;
  logic [3:0]   dp_constti;
  logic         dp_passthrough_en;
  logic [319:0] dp_randbits;

  modport slave (
    input  in_valid, in_sh0, in_sh1, rounds_sel, rnd_in, rnd_valid, out_ready,
    input  dp_Xo_sh0, dp_Xo_sh1,
    output in_ready, out_valid, out_sh0, out_sh1,
    output dp_Xi_sh0, dp_Xi_sh1, dp_rcmode, dp_constti, dp_passthrough_en, dp_randbits
  );

  modport master (
    output in_valid, in_sh0, in_sh1, rounds_sel, rnd_in, rnd_valid, out_ready,
    output dp_Xo_sh0, dp_Xo_sh1,
    input  in_ready, out_valid, out_sh0, out_sh1,
    input  dp_Xi_sh0, dp_Xi_sh1, dp_rcmode, dp_constti, dp_passthrough_en, dp_randbits
  );
endinterface

// File: rtl/ascon_perm_sequencer_dom.sv
// Round sequencer for a two-share (DOM) Ascon permutation. It holds the masked
// state, issues one round at a time to an external masked datapath of fixed
// latency LAT, stalls while no fresh randomness is available, and hands the
// permuted shares out through a valid/ready handshake. The two shares travel
// on strictly separate paths and are never mixed in any gate or register.
module ascon_perm_sequencer_dom #(
  parameter int LAT = 1
) (
  input  logic                     clk,
  input  logic                     RST,
  ascon_perm_sequencer_dom_if.slave bus
);
  localparam int DATA_W = 320;
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] sh0;
  logic [DATA_W-1:0] sh1;
  logic [1:0]        rcmode;
  logic [3:0]        rc;
  logic [3:0]        constti;
  logic [2:0]        wcnt;
  logic              load;
  logic              issue;
  logic              capture;
  logic              last_round;

  function automatic logic [3:0] round_count(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd8;
      2'b10:   return 4'd6;
      default: return 4'd12;
    endcase
  endfunction

  // Shorter permutations run the tail of the 12-round constant schedule.
  function automatic logic [3:0] start_index(input logic [1:0] sel);
    return 4'd12 - round_count(sel);
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the one-cycle strobes that drive the datapath regs.
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    last_round = (rc + 4'd1) == round_count(rcmode);
    case (state)
      IDLE: if (bus.in_valid) begin
        load      = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: if (bus.rnd_valid) begin
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (wcnt == 3'd1) begin
        capture   = 1'b1;
        state_nxt = last_round ? DONE : ISSUE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Share registers: each share loads only from its own input or datapath share.
  always_ff @(posedge clk) begin
    if (RST) begin
      sh0 <= '0;
      sh1 <= '0;
    end else if (load) begin
      sh0 <= bus.in_sh0;
      sh1 <= bus.in_sh1;
    end else if (capture) begin
      sh0 <= bus.dp_Xo_sh0;
      sh1 <= bus.dp_Xo_sh1;
    end
  end

  // Round, constant-index and latency counters; the constant index stops at
  // the final round so it never runs past 11.
  always_ff @(posedge clk) begin
    if (RST) begin
      rcmode  <= 2'b00;
      rc      <= 4'd0;
      constti <= 4'd0;
      wcnt    <= 3'd0;
    end else begin
      if (load) begin
        rcmode  <= bus.rounds_sel;
        rc      <= 4'd0;
        constti <= start_index(bus.rounds_sel);
      end
      if (issue)                               wcnt <= LAT_CNT;
      else if (state == WAIT && wcnt != 3'd0)  wcnt <= wcnt - 3'd1;
      if (capture) begin
        rc <= rc + 4'd1;
        if (!last_round) constti <= constti + 4'd1;
      end
    end
  end

  assign bus.in_ready          = RST | (state == IDLE);
  assign bus.out_valid         = ~RST & (state == DONE);
  assign bus.out_sh0           = RST ? '0 : sh0;
  assign bus.out_sh1           = RST ? '0 : sh1;
  assign bus.dp_Xi_sh0         = RST ? '0 : sh0;
  assign bus.dp_Xi_sh1         = RST ? '0 : sh1;
  assign bus.dp_rcmode         = rcmode;
  assign bus.dp_constti        = constti;
  assign bus.dp_passthrough_en = RST | ~issue;
  assign bus.dp_randbits       = (issue && !RST) ? bus.rnd_in : '0;
endmodule

// File: tb/tb_ascon_perm_sequencer_dom.sv
// Self-checking bench for the two-share Ascon permutation sequencer. A
// behavioural masked datapath (unmask, one plain Ascon round, re-split with the
// issued randomness) answers the sequencer; results are compared against a
// plain unmasked reference permutation and the round schedule implied by the
// selected round count.
module tb_ascon_perm_sequencer_dom;
  localparam int LAT = 1;

  logic clk;
  logic RST;
  int   tests;
  int   fails;

  ascon_perm_sequencer_dom_if bus();

  ascon_perm_sequencer_dom #(.LAT(LAT)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations recorded by the job driver for the tests to judge.
  int iss_cyc[$];
  int iss_idx[$];
  bit iss_rb[$];
  int stall_idx[$];
  bit stall_pt[$];
  int pt_rb_bad;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, 4'hf - i, i};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic int rounds_of(input logic [1:0] sel);
    return (sel == 2'b01) ? 8 : (sel == 2'b10) ? 6 : 12;
  endfunction

  function automatic logic [319:0] golden_perm(input logic [319:0] s, input int n);
    logic [319:0] t;
    t = s;
    for (int i = 12 - n; i < 12; i++) t = ascon_round(t, 4'(i));
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Masked datapath model: result ready one cycle after issue, held until next issue.
  always @(posedge clk) begin
    if (!bus.dp_passthrough_en) begin
      bus.dp_Xo_sh0 <= ascon_round(bus.dp_Xi_sh0 ^ bus.dp_Xi_sh1, bus.dp_constti) ^ bus.dp_randbits;
      bus.dp_Xo_sh1 <= bus.dp_randbits;
    end
  end

  // Loads one job and runs it until out_valid, stalling randomness for
  // stall_len cycles starting where round stall_at would issue.
  task automatic run_job(input logic [1:0] sel, input logic [319:0] s0, input logic [319:0] s1,
                         input int stall_at, input int stall_len,
                         output int lat, output logic [319:0] r0, output logic [319:0] r1);
    int cyc;
    int stall_start;
    logic [319:0] rnd;
    iss_cyc.delete(); iss_idx.delete(); iss_rb.delete();
    stall_idx.delete(); stall_pt.delete();
    pt_rb_bad   = 0;
    stall_start = 1 + stall_at * (LAT + 1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sh0 = s0; bus.in_sh1 = s1; bus.rounds_sel = sel;
    bus.rnd_valid = 1'b1; bus.rnd_in = rand320(); bus.out_ready = 1'b0;
    @(posedge clk);
    lat = -1;
    cyc = 1;
    while (cyc < 200 && lat < 0) begin
      @(negedge clk);
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.in_sh0     = rand320();
      bus.in_sh1     = rand320();
      bus.rounds_sel = 2'($urandom);
      rnd            = rand320();
      bus.rnd_in     = rnd;
      bus.rnd_valid  = !(stall_at >= 0 && cyc >= stall_start && cyc < stall_start + stall_len);
      #1;
      if (!bus.rnd_valid) begin
        stall_idx.push_back(int'(bus.dp_constti));
        stall_pt.push_back(bus.dp_passthrough_en);
      end
      if (!bus.dp_passthrough_en) begin
        iss_cyc.push_back(cyc);
        iss_idx.push_back(int'(bus.dp_constti));
        iss_rb.push_back(bus.dp_randbits == rnd);
      end else if (bus.dp_randbits != '0) begin
        pt_rb_bad++;
      end
      if (bus.out_valid) lat = cyc;
      cyc++;
    end
    r0 = bus.out_sh0;
    r1 = bus.out_sh1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.in_valid = 1'b0; bus.in_sh0 = '0; bus.in_sh1 = '0; bus.rounds_sel = 2'b00;
    bus.rnd_in = '0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.dp_passthrough_en !== 1'b1 || bus.dp_randbits !== '0) begin
      fails++; $display("FAIL reset_dp: passthrough=%b randbits_nonzero=%b want 1 0",
                        bus.dp_passthrough_en, |bus.dp_randbits);
    end
    tests++;
    if ((bus.out_sh0 | bus.out_sh1 | bus.dp_Xi_sh0 | bus.dp_Xi_sh1) !== '0 ||
        bus.dp_constti !== 4'd0 || bus.dp_rcmode !== 2'd0) begin
      fails++; $display("FAIL reset_regs: constti=%0d rcmode=%0d shares_nonzero=%b want 0 0 0",
                        bus.dp_constti, bus.dp_rcmode, |(bus.out_sh0 | bus.out_sh1));
    end
  endtask

  task automatic test_round_counts();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] sel;
      int n, s, lat, bad;
      logic [319:0] x, m, r0, r1;
      sel = 2'(k);
      n   = rounds_of(sel);
      s   = 12 - n;
      x   = rand320();
      m   = rand320();
      run_job(sel, x ^ m, m, -1, 0, lat, r0, r1);
      tests++;
      if (lat !== n * (LAT + 1) + 1) begin
        fails++; $display("FAIL latency_sel%0d: got %0d want %0d", k, lat, n * (LAT + 1) + 1);
      end
      bad = (iss_idx.size() != n) ? 1 : 0;
      for (int i = 0; i < n; i++)
        if (i >= iss_idx.size() || iss_idx[i] != s + i || iss_cyc[i] != 1 + i * (LAT + 1) || !iss_rb[i])
          bad++;
      tests++;
      if (bad !== 0) begin
        fails++; $display("FAIL schedule_sel%0d: %0d bad issues out of %0d (first index %0d want %0d)",
                          k, bad, iss_idx.size(), (iss_idx.size() > 0) ? iss_idx[0] : -1, s);
      end
      tests++;
      if (pt_rb_bad !== 0) begin
        fails++; $display("FAIL randbits_idle_sel%0d: %0d nonzero cycles want 0", k, pt_rb_bad);
      end
      tests++;
      if ((r0 ^ r1) !== golden_perm(x, n)) begin
        fails++; $display("FAIL result_sel%0d: got %h want %h", k, r0 ^ r1, golden_perm(x, n));
      end
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL release_sel%0d: in_ready=%b out_valid=%b want 1 0", k, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int lat, bad;
    logic [319:0] x, m, r0, r1;
    x = rand320();
    m = rand320();
    run_job(2'b00, x ^ m, m, 3, 3, lat, r0, r1);
    tests++;
    if (lat !== 12 * (LAT + 1) + 1 + 3) begin
      fails++; $display("FAIL stall_latency: got %0d want %0d", lat, 12 * (LAT + 1) + 4);
    end
    bad = (stall_idx.size() != 3) ? 1 : 0;
    for (int i = 0; i < stall_idx.size(); i++)
      if (stall_idx[i] != 3 || !stall_pt[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL stall_hold: %0d bad stall cycles of %0d (want constti 3, passthrough 1)",
                        bad, stall_idx.size());
    end
    bad = (iss_idx.size() != 12) ? 1 : 0;
    for (int i = 0; i < iss_idx.size(); i++)
      if (iss_idx[i] != i) bad++;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL stall_schedule: %0d bad of %0d issues", bad, iss_idx.size());
    end
    tests++;
    if ((r0 ^ r1) !== golden_perm(x, 12)) begin
      fails++; $display("FAIL stall_result: got %h want %h", r0 ^ r1, golden_perm(x, 12));
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [319:0] x, m, r0, r1;
    x = rand320();
    m = rand320();
    run_job(2'b10, x ^ m, m, -1, 0, lat, r0, r1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_sh0 = rand320(); bus.in_sh1 = rand320();
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sh0 !== r0 || bus.out_sh1 !== r1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL bp_stable: %0d unstable cycles of 5 want 0", bad);
    end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.out_sh0 !== r0 || bus.out_sh1 !== r1) begin
      fails++; $display("FAIL bp_no_load: out_sh0=%h want %h", bus.out_sh0, r0);
    end
  endtask

  task automatic test_share_indep();
    int lat;
    logic [319:0] x, m1, m2, a0, a1, b0, b1;
    x  = rand320();
    m1 = rand320();
    m2 = rand320();
    run_job(2'b10, x ^ m1, m1, -1, 0, lat, a0, a1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    run_job(2'b10, x ^ m2, m2, -1, 0, lat, b0, b1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++;
    if ((a0 ^ a1) !== (b0 ^ b1) || (a0 ^ a1) !== golden_perm(x, 6)) begin
      fails++; $display("FAIL indep_result: split1 %h split2 %h want %h", a0 ^ a1, b0 ^ b1, golden_perm(x, 6));
    end
    tests++;
    if (a0 === b0) begin
      fails++; $display("FAIL indep_shares: out_sh0 %h identical across splits, want different", a0);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sh0 = rand320(); bus.in_sh1 = rand320();
    bus.rounds_sel = 2'b00; bus.rnd_valid = 1'b1; bus.rnd_in = rand320();
    @(posedge clk);
    repeat (3) @(negedge clk);
    @(negedge clk);
    RST = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dp_passthrough_en !== 1'b1 ||
        bus.dp_randbits !== '0 || (bus.out_sh0 | bus.dp_Xi_sh1) !== '0) begin
      fails++; $display("FAIL rst_asserted: in_ready=%b out_valid=%b passthrough=%b want 1 0 1",
                        bus.in_ready, bus.out_valid, bus.dp_passthrough_en);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        (bus.out_sh0 | bus.out_sh1 | bus.dp_Xi_sh0 | bus.dp_Xi_sh1) !== '0) begin
      fails++; $display("FAIL rst_midrun: in_ready=%b out_valid=%b shares_nonzero=%b want 1 0 0",
                        bus.in_ready, bus.out_valid, |(bus.out_sh0 | bus.out_sh1));
    end
    tests++;
    if (bus.dp_constti !== 4'd0 || bus.dp_rcmode !== 2'd0 || bus.dp_passthrough_en !== 1'b1) begin
      fails++; $display("FAIL rst_midrun_ctrl: constti=%0d rcmode=%0d passthrough=%b want 0 0 1",
                        bus.dp_constti, bus.dp_rcmode, bus.dp_passthrough_en);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_counts();
    test_stall();
    test_backpressure();
    test_share_indep();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ascon_perm_sequencer_dom.md
ASCON_PERM_SEQUENCER_DOM -- requirements
Module: ascon_perm_sequencer_dom

Interface
REQ-001 Parameter LAT, default 1: clock cycles from round issue to valid masked datapath output (range 1-4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  load request for a new masked state.
REQ-005 in_ready  output  1  sequencer can accept a load.
REQ-006 in_sh0 / in_sh1  input  320 each  state shares; X0 in bits [319:256], X4 in bits [63:0].
REQ-007 rounds_sel  input  2  round count, sampled at load: 00=12, 01=8, 10=6, 11=12.
REQ-008 rnd_in  input  320  fresh DOM randomness.
REQ-009 rnd_valid  input  1  rnd_in is fresh this cycle.
REQ-010 out_valid  output  1  result shares valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sh0 / out_sh1  output  320 each  permuted state shares, same layout as REQ-006.
REQ-013 dp_Xi_sh0 / dp_Xi_sh1  output  320 each  round inputs to masked datapath.
REQ-014 dp_Xo_sh0 / dp_Xo_sh1  input  320 each  round outputs from masked datapath.
REQ-015 dp_rcmode  output  2  latched rounds_sel.
REQ-016 dp_constti  output  4  current round-constant index.
REQ-017 dp_passthrough_en  output  1  datapath hold/bypass control.
REQ-018 dp_randbits  output  320  randomness to datapath.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 IDLE with in_valid=1: shares into state regs sh0/sh1, rounds_sel latched, round counter=0, next ISSUE.
REQ-022 Start index S: 0 for 12 rounds, 4 for 8, 6 for 6; dp_constti SHALL equal S + round counter (4-bit, never exceeds 11).
REQ-023 ISSUE with rnd_valid=1: dp_passthrough_en=0, dp_randbits=rnd_in, next WAIT with wait counter=LAT.
REQ-024 ISSUE with rnd_valid=0: stay in ISSUE, dp_passthrough_en=1, dp_randbits=0, counters unchanged (stall).
REQ-025 dp_passthrough_en SHALL be 1 and dp_randbits 0 in all states other than an issuing ISSUE cycle.
REQ-026 dp_Xi_sh0/sh1 SHALL equal state regs sh0/sh1 in every state.
REQ-027 WAIT: wait counter decrements; on its last cycle (count 1) dp_Xo_sh0/sh1 SHALL load into sh0/sh1 and round counter increment.
REQ-028 After capture: round counter equal to round count -> DONE, else -> ISSUE.
REQ-029 One round SHALL take LAT+1 cycles with rnd_valid held high; load-to-out_valid latency = n*(LAT+1)+1 cycles.
REQ-030 DONE: out_sh0/sh1 = state regs, held stable while out_ready=0; out_valid & out_ready -> IDLE next cycle.
REQ-031 Load and result handshakes SHALL never overlap (in_ready=0 in DONE); no back-to-back bypass.
REQ-032 Shares SHALL never be combined: no logic may read bits of both sh0 and sh1 (or both input shares) into one gate or register.
REQ-033 in_valid outside IDLE SHALL be ignored; rounds_sel changes after load SHALL have no effect.

Reset
REQ-034 RST=1 at an edge SHALL force IDLE, state regs, counters, dp_rcmode, dp_constti to 0, regardless of current state (including mid-run).
REQ-035 Output values with RST asserted and in the first cycle after: in_ready=1, out_valid=0, dp_passthrough_en=1, dp_randbits=0, out_sh*/dp_Xi_sh* = 0.
REQ-036 RST overrides in_valid and out_ready in the same cycle.

Verification
REQ-037 Reset: RST high 2 cycles mid-WAIT -> IDLE, in_ready=1, out_valid=0, all shares 0 next cycle.
REQ-038 p12, LAT=1, rnd_valid=1: load at cycle 0 -> dp_constti 0..11 on issue cycles 1,3,...,23; out_valid at cycle 25; out_sh0 XOR out_sh1 equals golden unmasked permutation of in_sh0 XOR in_sh1.
REQ-039 p6 (rounds_sel=10): dp_constti 6..11 only; out_valid at cycle 13; rounds_sel=11 -> behaves as p12.
REQ-040 Stall: rnd_valid=0 for 3 cycles at round 3 issue -> dp_constti held at 3, passthrough_en=1, latency +3 cycles, unmasked result unchanged.
REQ-041 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_sh* stable, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-042 Share independence: same unmasked input with two different share splits and randomness -> identical unmasked result, different out_sh0.
